// File: rtl/tff_pulse_sequencer_pkg.sv
// Shared constants for the T flip-flop pulse sequencer: state encoding and
// default widths of the toggle-count and period fields.
package tff_pulse_sequencer_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int DIV_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tff_pulse_sequencer_tff_cell.sv
// T flip-flop: q inverts on every rising edge where t is high, cleared by
// synchronous active-high reset.
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 1'b0;
    end else if (t) begin
      r_q <= ~r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/tff_pulse_sequencer.sv
// Issues a burst of n_toggles enables to a T flip-flop, spaced period idle
// cycles apart, with abort, a done pulse and a remaining-toggle count.
module tff_pulse_sequencer
  import tff_pulse_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_toggles,
  input  logic [DIV_W-1:0] period,
  output logic             tff_en,
  output logic             q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a request accepted only while the FSM is in IDLE
  // (implicit ready = !busy && !done); abort is honoured only while busy.
  state_t           r_state;
  logic [CNT_W-1:0] r_rem;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_period;
  logic             w_fire;

  assign w_fire = (r_state == ST_RUN) && (r_div == '0) && !abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rem    <= '0;
      r_div    <= '0;
      r_period <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (n_toggles != '0) begin
              r_rem    <= n_toggles;
              r_div    <= period;
              r_period <= period;
              r_state  <= ST_RUN;
            end else begin
              r_state  <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          // Abort beats a coincident final toggle: count and q both hold.
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (r_div != '0) begin
            r_div <= r_div - DIV_W'(1);
          end else begin
            r_div <= r_period;
            if (r_rem != '0) begin
              r_rem <= r_rem - CNT_W'(1);
            end
            if (r_rem <= CNT_W'(1)) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are quiet for the whole reset cycle, not just after its edge.
  assign tff_en    = w_fire && !reset;
  assign busy      = (r_state == ST_RUN) && !reset;
  assign done      = (r_state == ST_DONE) && !reset;
  assign remaining = reset ? '0 : r_rem;
  assign dbg_state = r_state;

  tff_cell u_tff (
    .clk   (clk),
    .reset (reset),
    .t     (tff_en),
    .q     (q)
  );

endmodule

// File: tb/tb_tff_pulse_sequencer.sv
// Bench for tff_pulse_sequencer: a time-based burst model checked every
// cycle, plus hand-computed per-scenario masks of enable/busy/done cycles.
module tb_tff_pulse_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] n_toggles;
  logic [3:0] period;
  logic       tff_en;
  logic       q;
  logic       busy;
  logic       done;
  logic [7:0] remaining;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;

  tff_pulse_sequencer #(.CNT_W(8), .DIV_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .n_toggles (n_toggles),
    .period    (period),
    .tff_en    (tff_en),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // model: mode 0 idle, 1 running, 2 done pulse
  int   cyc = 0;
  int   m_mode = 0;
  int   m_s, m_n, m_p;
  int   m_rem = 0;
  logic m_q = 1'b0;
  bit   model_on = 1'b0;

  always @(negedge clk) begin
    int   e_en, e_busy, e_done, e_rem, t, issued, old_mode;
    logic old_q;
    cyc++;
    e_en = 0; e_busy = 0; e_done = 0; e_rem = m_rem;
    old_q = m_q; old_mode = m_mode;
    if (reset) begin
      e_rem = 0;
      old_mode = 0;
    end else if (m_mode == 1) begin
      t      = cyc - m_s;
      issued = (t - 1) / (m_p + 1);
      e_busy = 1;
      e_rem  = m_n - issued;
      e_en   = ((t % (m_p + 1)) == 0 && !abort) ? 1 : 0;
    end else if (m_mode == 2) begin
      e_done = 1;
    end
    if (model_on) begin
      chk("tff_en", int'(tff_en), e_en);
      chk("busy", int'(busy), e_busy);
      chk("done", int'(done), e_done);
      chk("q", int'(q), int'(old_q));
      chk("remaining", int'(remaining), e_rem);
      if (!reset) chk("state", int'(dbg_state), old_mode);
    end
    if (reset) begin
      m_mode = 0; m_q = 1'b0; m_rem = 0; model_on = 1'b1;
    end else begin
      case (m_mode)
        0: if (start) begin
          if (n_toggles != 0) begin
            m_mode = 1; m_s = cyc; m_n = int'(n_toggles); m_p = int'(period);
          end else begin
            m_mode = 2;
          end
        end
        1: begin
          if (abort) begin
            m_mode = 0; m_rem = e_rem;
          end else if (e_en == 1) begin
            m_q = ~m_q;
            m_rem = e_rem - 1;
            if (issued + 1 == m_n) m_mode = 2;
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  // driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 carries start; cycles 1..len may carry abort, reset or a
  // second start (n=7, period=0) that must be ignored.
  task automatic run_burst(input int n, input int p, input int ab_c,
                           input int rs_c, input int rst_c, input int len,
                           output int en_m, output int bs_m, output int dn_m);
    tick();
    start = 1'b1; n_toggles = 8'(n); period = 4'(p); abort = 1'b0; reset = 1'b0;
    en_m = 0; bs_m = 0; dn_m = 0;
    for (int c = 1; c <= len; c++) begin
      tick();
      start = (c == rst_c);
      if (c == rst_c) begin
        n_toggles = 8'd7; period = 4'd0;
      end
      abort = (c == ab_c);
      reset = (c == rs_c);
      #1;
      if (tff_en) en_m |= (1 << c);
      if (busy)   bs_m |= (1 << c);
      if (done)   dn_m |= (1 << c);
    end
    tick();
    start = 1'b0; abort = 1'b0; reset = 1'b0;
  endtask

  initial begin
    int en_m, bs_m, dn_m;
    reset = 1'b1; start = 1'b0; abort = 1'b0; n_toggles = '0; period = '0;
    repeat (2) tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_rem", int'(remaining), 0);
    reset = 1'b0;
    tick();
    chk("post_reset_q", int'(q), 0);

    // four back-to-back toggles
    run_burst(4, 0, 0, 0, 0, 6, en_m, bs_m, dn_m);
    chk("s1_en", en_m, 32'h1E);
    chk("s1_busy", bs_m, 32'h1E);
    chk("s1_done", dn_m, 32'h20);
    chk("s1_q", int'(q), 0);

    // three toggles, two idle cycles apart
    run_burst(3, 2, 0, 0, 0, 11, en_m, bs_m, dn_m);
    chk("s2_en", en_m, 32'h248);
    chk("s2_done", dn_m, 32'h400);
    chk("s2_q", int'(q), 1);
    chk("s2_rem", int'(remaining), 0);

    // zero-length burst
    run_burst(0, 3, 0, 0, 0, 3, en_m, bs_m, dn_m);
    chk("s3_busy", bs_m, 0);
    chk("s3_done", dn_m, 32'h2);
    chk("s3_q", int'(q), 1);

    // abort mid-burst from q=0
    reset = 1'b1; tick(); reset = 1'b0;
    run_burst(5, 1, 4, 0, 0, 6, en_m, bs_m, dn_m);
    chk("s4_en", en_m, 32'h4);
    chk("s4_busy", bs_m, 32'h1E);
    chk("s4_done", dn_m, 0);
    chk("s4_q", int'(q), 1);
    chk("s4_rem", int'(remaining), 4);

    // reset mid-burst
    run_burst(8, 0, 0, 3, 0, 4, en_m, bs_m, dn_m);
    chk("s5_en", en_m, 32'h6);
    chk("s5_busy", bs_m, 32'h6);
    chk("s5_done", dn_m, 0);
    chk("s5_q", int'(q), 0);

    // second start while busy must not recapture
    run_burst(3, 1, 0, 0, 2, 8, en_m, bs_m, dn_m);
    chk("s6_en", en_m, 32'h54);
    chk("s6_done", dn_m, 32'h80);
    chk("s6_q", int'(q), 1);

    // abort on the only toggle
    run_burst(1, 0, 1, 0, 0, 3, en_m, bs_m, dn_m);
    chk("s7_en", en_m, 0);
    chk("s7_busy", bs_m, 32'h2);
    chk("s7_done", dn_m, 0);
    chk("s7_q", int'(q), 1);
    chk("s7_rem", int'(remaining), 1);

    // extra patterns checked by the model alone
    run_burst(2, 3, 0, 0, 0, 10, en_m, bs_m, dn_m);
    run_burst(6, 1, 0, 0, 0, 14, en_m, bs_m, dn_m);
    run_burst(1, 15, 0, 0, 0, 18, en_m, bs_m, dn_m);
    run_burst(7, 2, 11, 0, 0, 13, en_m, bs_m, dn_m);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tff_pulse_sequencer.md
TFF_PULSE_SEQUENCER -- requirements
Module: tff_pulse_sequencer

Interface
REQ-001 Parameter CNT_W, default 8, width of the toggle-count request and remaining-count output.
REQ-002 Parameter DIV_W, default 4, width of the inter-toggle period field.
REQ-003 Port clk, input, 1, single system clock; all state updates on rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Port start, input, 1, request a toggle burst; sampled only in IDLE.
REQ-006 Port abort, input, 1, terminate a burst in progress; sampled only in RUN.
REQ-007 Port n_toggles, input, CNT_W, number of toggles in the burst; captured with start.
REQ-008 Port period, input, DIV_W, idle cycles between toggles; captured with start.
REQ-009 Port tff_en, output, 1, enable to the T flip-flop, high for exactly the cycles in which Q is to toggle.
REQ-010 Port q, output, 1, T flip-flop state.
REQ-011 Port busy, output, 1, high in RUN.
REQ-012 Port done, output, 1, one-cycle pulse on normal burst completion.
REQ-013 Port remaining, output, CNT_W, toggles not yet issued in the current burst.

Function
REQ-014 States: IDLE, RUN, DONE; encoded as 2-bit state.
REQ-015 IDLE, start=1, n_toggles!=0: load rem=n_toggles, div=period, next RUN.
REQ-016 IDLE, start=1, n_toggles=0: no load, next DONE; no toggle issued.
REQ-017 IDLE, start=0: hold; tff_en=0, busy=0, done=0.
REQ-018 RUN: tff_en = (div==0) AND NOT abort, combinational from registered state.
REQ-019 RUN, div!=0, abort=0: div decrements by 1.
REQ-020 RUN, div==0, abort=0: div reloads captured period, rem decrements by 1; rem==1 before decrement -> next DONE.
REQ-021 RUN, abort=1: next IDLE, tff_en=0 that cycle, done not pulsed, q holds, remaining holds last value until next start.
REQ-022 abort and final toggle in the same cycle: abort wins; no toggle, no done.
REQ-023 start asserted outside IDLE: ignored, no recapture of n_toggles or period.
REQ-024 DONE: done=1 for one cycle, tff_en=0, next IDLE unconditionally.
REQ-025 Timing: start sampled at edge of cycle 0 -> toggles enabled in cycles (period+1)*k, k=1..n_toggles; done in cycle n_toggles*(period+1)+1.
REQ-026 q inverts at the rising edge ending every cycle with tff_en=1, else holds; q is not cleared between bursts.
REQ-027 period=0: one toggle per cycle, back-to-back.
REQ-028 rem and div use unsigned wrap-free arithmetic; rem never decrements below 0.

Reset
REQ-029 reset=1 at a rising edge forces state=IDLE, q=0, rem=0, div=0, captured period=0.
REQ-030 While reset=1: tff_en=0, busy=0, done=0, remaining=0; reset overrides start and abort.
REQ-031 reset mid-burst discards the burst; no done pulse after release.

Structure
REQ-032 Shared package holds the state encoding constants (IDLE=0, RUN=1, DONE=2) and default CNT_W/DIV_W values.
REQ-033 T flip-flop is a sub-module tff_cell (ports clk, reset, t, q), instantiated once, t driven by tff_en.
REQ-034 Sequencer FSM, rem counter, and div counter live in the top module; no other sub-modules.

Verification
REQ-035 reset, then start with n_toggles=4, period=0 -> tff_en high cycles 1-4, q 0->1->0->1->0, done in cycle 5, busy cycles 1-4.
REQ-036 start with n_toggles=3, period=2 from q=0 -> tff_en in cycles 3, 6, 9, final q=1, done in cycle 10, remaining 3->2->1->0.
REQ-037 start with n_toggles=0 -> done in cycle 1, busy never high, q unchanged.
REQ-038 n_toggles=5, period=1, abort in cycle 4 -> toggles only in cycle 2, q=1, IDLE in cycle 5, no done, remaining=4.
REQ-039 n_toggles=8, period=0, reset in cycle 3 -> q=0, tff_en=0, busy=0 from cycle 4, no done; start in cycle 5 ignored while busy=1 on a new burst.
REQ-040 abort coincident with last-toggle cycle (n_toggles=1, period=0, abort in cycle 1) -> no toggle, no done, q unchanged.
